vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA sync driver.
- Generates H/V timing for any resolution and porch set, with configurable sync polarity and colour width.
- Issues pixel requests to the display/game logic and compensates a configurable pixel-data return latency, so sync, DE and RGB leave aligned.
- Adds clean start/stop at frame boundaries, line/frame strobes and a frame counter.
- Sits between the PLL pixel clock and the display-content block.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, FSM encoding and width helper for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vga_state_e;

  // 640x480 @ 60 Hz
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;

  // Counter width for a count range of 0..total-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised-depth shift register with a reset value; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-request latency compensation.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned RGB_W    = 24,
  parameter int unsigned DATA_LAT = 1,
  parameter int unsigned FCNT_W   = 16,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW      = cnt_width(H_TOTAL),
  localparam int unsigned CW_V    = cnt_width(V_TOTAL)
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [RGB_W-1:0]  pixel_data,
  output logic              pixel_req,
  output logic [CW-1:0]     pixel_xpos,
  output logic [CW_V-1:0]   pixel_ypos,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [RGB_W-1:0]  vga_rgb
);

  if (RGB_W == 0 || FCNT_W == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_width
    $error("vga_timing_gen: width parameters must be non-zero");
  end
  if (DATA_LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: DATA_LAT must be in 0..8");
  end

  localparam logic [CW-1:0]   H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW_V-1:0] V_LAST = CW_V'(V_TOTAL - 1);

  vga_state_e        state_q, state_d;
  logic [CW-1:0]     h_cnt_q, h_cnt_d;
  logic [CW_V-1:0]   v_cnt_q, v_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              running, h_last, frame_last;
  logic              hs_raw, vs_raw, de_raw;
  logic              hs_dly, vs_dly, de_dly;
  logic              vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_de_q, vga_de_d;
  logic [RGB_W-1:0]  vga_rgb_q, vga_rgb_d;

  assign h_last     = (h_cnt_q == H_LAST);
  assign frame_last = h_last && (v_cnt_q == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STOPPING keeps counting like RUN so a re-raised enable causes no timing jump.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:              if (enable) state_d = ST_RUN;
      ST_RUN, ST_STOPPING: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
        else                 state_d = ST_STOPPING;
      end
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running     = (state_q != ST_IDLE);
    busy        = running;
    de_raw      = running && (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    pixel_req   = de_raw;
    line_start  = running && (h_cnt_q == '0);
    frame_start = running && (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_raw      = running && (32'(h_cnt_q) >= H_ACTIVE + H_FP)
                          && (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    vs_raw      = running && (32'(v_cnt_q) >= V_ACTIVE + V_FP)
                          && (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
  end

  always_comb begin
    h_cnt_d     = '0;
    v_cnt_d     = '0;
    frame_cnt_d = frame_start ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    if (running) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + CW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW_V'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pixel_xpos = h_cnt_q;
  assign pixel_ypos = v_cnt_q;
  assign frame_cnt  = frame_cnt_q;

  // Raw levels are carried active-high; polarity is applied at the output register.
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (DATA_LAT),
    .RST_VAL (3'b000)
  ) u_dly (
    .clk (vga_clk),
    .rst (sys_rst),
    .d   ({hs_raw, vs_raw, de_raw}),
    .q   ({hs_dly, vs_dly, de_dly})
  );

  always_comb begin
    vga_hs_d  = hs_dly ? HS_POL : ~HS_POL;
    vga_vs_d  = vs_dly ? VS_POL : ~VS_POL;
    vga_de_d  = de_dly;
    vga_rgb_d = de_dly ? pixel_data : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vga_hs_q  <= ~HS_POL;
      vga_vs_q  <= ~VS_POL;
      vga_de_q  <= 1'b0;
      vga_rgb_q <= '0;
    end else begin
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
      vga_de_q  <= vga_de_d;
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign vga_hs  = vga_hs_q;
  assign vga_vs  = vga_vs_q;
  assign vga_de  = vga_de_q;
  assign vga_rgb = vga_rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-timing instances (DATA_LAT=2 active-low, DATA_LAT=0 active-high)
// and a default-parameter instance for reset values.
module tb_vga_timing_gen;

  localparam int unsigned HT = 14;
  localparam int unsigned FT = 112;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic        req_a, ls_a, fs_a, busy_a, hs_a, vs_a, de_a;
  logic [3:0]  x_a;
  logic [2:0]  y_a;
  logic [15:0] fc_a;
  logic [23:0] rgb_a, pd_a;

  logic        req_b, ls_b, fs_b, busy_b, hs_b, vs_b, de_b;
  logic [3:0]  x_b;
  logic [2:0]  y_b;
  logic [15:0] fc_b;
  logic [23:0] rgb_b, pd_b;

  logic        c_unused_req, c_unused_ls, c_unused_fs, busy_c, hs_c, vs_c, de_c;
  logic [9:0]  c_unused_x, c_unused_y;
  logic [15:0] fc_c;
  logic [23:0] rgb_c;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(24), .DATA_LAT(2), .FCNT_W(16)
  ) dut_a (
    .vga_clk(clk), .sys_rst(rst), .enable(en), .pixel_data(pd_a),
    .pixel_req(req_a), .pixel_xpos(x_a), .pixel_ypos(y_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a), .busy(busy_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(24), .DATA_LAT(0), .FCNT_W(16)
  ) dut_b (
    .vga_clk(clk), .sys_rst(rst), .enable(en), .pixel_data(pd_b),
    .pixel_req(req_b), .pixel_xpos(x_b), .pixel_ypos(y_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b), .busy(busy_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b)
  );

  vga_timing_gen dut_c (
    .vga_clk(clk), .sys_rst(rst), .enable(1'b0), .pixel_data(24'h123456),
    .pixel_req(c_unused_req), .pixel_xpos(c_unused_x), .pixel_ypos(c_unused_y),
    .line_start(c_unused_ls), .frame_start(c_unused_fs), .frame_cnt(fc_c), .busy(busy_c),
    .vga_hs(hs_c), .vga_vs(vs_c), .vga_de(de_c), .vga_rgb(rgb_c)
  );

  // Content model: returns {y,x} DATA_LAT cycles after a request, junk otherwise.
  logic [6:0] p1, p2;
  logic       r1, r2;
  always @(posedge clk) begin
    p1 <= {y_a, x_a};
    r1 <= req_a;
    p2 <= p1;
    r2 <= r1;
  end
  assign pd_a = r2 ? {17'h0, p2} : 24'hA5A5A5;
  assign pd_b = req_b ? {17'h0, y_b, x_b} : 24'h5A5A5A;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: 0 idle, 1 run, 2 stopping; m_pos = v*HT + h
  int m_state = 0;
  int m_pos   = 0;
  int m_fcnt  = 0;
  logic [26:0] qa[$];
  logic [26:0] qb[$];

  typedef struct {
    int h; int v;
    bit req; bit ls; bit fs;
    bit hs; bit vs; bit de;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, step the model, and compare both small instances against it.
  task automatic tick();
    int h, v;
    bit run, fin, req, hsr, vsr;
    logic [23:0] rgb_e;
    logic [26:0] e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      m_state = 0; m_pos = 0; m_fcnt = 0;
      qa.delete(); qb.delete();
      repeat (3) qa.push_back({1'b1, 1'b1, 1'b0, 24'h0});
      qb.push_back({1'b0, 1'b0, 1'b0, 24'h0});
    end else begin
      run = (m_state != 0);
      fin = (m_pos == FT - 1);
      if (run && m_pos == 0) m_fcnt = (m_fcnt + 1) % 65536;
      if (run) m_pos = fin ? 0 : m_pos + 1;
      if (en) m_state = 1;
      else if (m_state != 0) m_state = fin ? 0 : 2;
    end
    h   = m_pos % HT;
    v   = m_pos / HT;
    run = (m_state != 0);
    req = run && h < 8 && v < 4;
    hsr = run && h >= 10 && h < 13;
    vsr = run && v >= 5 && v < 7;
    rgb_e = req ? {17'h0, 3'(v), 4'(h)} : 24'h0;
    check("ctrlA", 64'({req_a, x_a, y_a, ls_a, fs_a, busy_a, fc_a}),
          64'({req, 4'(h), 3'(v), run && h == 0, run && m_pos == 0, run, 16'(m_fcnt)}));
    check("ctrlB", 64'({req_b, x_b, y_b, ls_b, fs_b, busy_b, fc_b}),
          64'({req, 4'(h), 3'(v), run && h == 0, run && m_pos == 0, run, 16'(m_fcnt)}));
    qa.push_back({~hsr, ~vsr, req, rgb_e});
    e = qa.pop_front();
    check("sbA", 64'({hs_a, vs_a, de_a, rgb_a}), 64'(e));
    qb.push_back({hsr, vsr, req, rgb_e});
    e = qb.pop_front();
    check("sbB", 64'({hs_b, vs_b, de_b, rgb_b}), 64'(e));
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int n = 0;
    while (!(busy_a && x_a == 4'(h) && y_a == 3'(v)) && n < 300) begin
      tick();
      n++;
    end
    check({"timeout_", name}, 64'(n >= 300), 64'd0);
  endtask

  initial begin
    int n, ka, kb, c0, c1, c2, c3, c4, t0, f0;
    logic [23:0] rgb_first;
    logic [6:0]  last_pos;
    bit seen;

    vecs[0] = '{0, 0, 1, 1, 1, 1, 1, 1};
    vecs[1] = '{0, 1, 1, 1, 0, 1, 1, 1};
    vecs[2] = '{10, 2, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{7, 3, 1, 0, 0, 1, 1, 1};
    vecs[4] = '{8, 3, 0, 0, 0, 1, 1, 0};
    vecs[5] = '{12, 5, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{13, 5, 0, 0, 0, 1, 0, 0};
    vecs[7] = '{0, 6, 0, 1, 0, 1, 0, 0};
    vecs[8] = '{3, 7, 0, 0, 0, 1, 1, 0};

    // Reset values on the default-parameter instance
    rst = 1'b1; en = 1'b0;
    repeat (3) tick();
    check("rst_c_sync", 64'({hs_c, vs_c}), 64'h3);
    check("rst_c_de_rgb", 64'({de_c, rgb_c}), 64'h0);
    check("rst_c_busy_fcnt", 64'({busy_c, fc_c}), 64'h0);
    rst = 1'b0;
    tick();

    // First request latency and colour
    en = 1'b1;
    n = 0;
    while (!req_a && n < 50) begin tick(); n++; end
    check("timeout_first_req", 64'(n >= 50), 64'd0);
    ka = -1; kb = -1; rgb_first = 24'hFFFFFF;
    for (int k = 0; k < 10; k++) begin
      if (ka < 0 && de_a) begin ka = k; rgb_first = rgb_a; end
      if (kb < 0 && de_b) kb = k;
      tick();
    end
    check("de_latency_a", 64'(ka), 64'd3);
    check("de_latency_b", 64'(kb), 64'd1);
    check("first_rgb_a", 64'(rgb_first), 64'h0);

    // Sync widths over one line and one frame
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    for (int k = 0; k < int'(FT); k++) begin
      if (k < int'(HT) && !hs_a) c0++;
      if (!hs_a) c1++;
      if (!vs_a) c2++;
      if (hs_b) c3++;
      if (vs_b) c4++;
      tick();
    end
    check("hs_low_per_line_a", 64'(c0), 64'd3);
    check("hs_low_per_frame_a", 64'(c1), 64'd24);
    check("vs_low_per_frame_a", 64'(c2), 64'd28);
    check("hs_high_per_frame_b", 64'(c3), 64'd24);
    check("vs_high_per_frame_b", 64'(c4), 64'd28);

    // Position vectors
    for (int i = 0; i < 9; i++) begin
      wait_pos(vecs[i].h, vecs[i].v, "vec");
      check("vec_ctrl", 64'({req_a, ls_a, fs_a}), 64'({vecs[i].req, vecs[i].ls, vecs[i].fs}));
      repeat (3) tick();
      check("vec_out", 64'({hs_a, vs_a, de_a, rgb_a}),
            64'({vecs[i].hs, vecs[i].vs, vecs[i].de,
                 vecs[i].de ? {17'h0, 3'(vecs[i].v), 4'(vecs[i].h)} : 24'h0}));
    end

    // Stop mid-frame: frame completes, then idle
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    wait_pos(5, 2, "stop");
    en = 1'b0;
    n = 0; last_pos = '0;
    while (busy_a && n < 200) begin last_pos = {y_a, x_a}; tick(); n++; end
    check("timeout_stop", 64'(n >= 200), 64'd0);
    check("stop_last_pos", 64'(last_pos), 64'({3'd7, 4'd13}));
    check("stop_fcnt", 64'(fc_a), 64'd1);
    repeat (3) tick();
    check("stop_outputs_idle", 64'({hs_a, vs_a, de_a, rgb_a}), 64'({2'b11, 25'h0}));
    seen = 1'b0;
    repeat (20) begin tick(); seen |= req_a | busy_a; end
    check("stop_stays_idle", 64'(seen), 64'd0);

    // Pause at v=1, resume at v=3: frames stay 112 cycles apart
    en = 1'b1;
    n = 0;
    while (!fs_a && n < 10) begin tick(); n++; end
    check("timeout_resume_fs0", 64'(n >= 10), 64'd0);
    t0 = cyc; f0 = int'(fc_a);
    wait_pos(0, 1, "pause");
    en = 1'b0;
    wait_pos(0, 3, "resume");
    en = 1'b1;
    for (int f = 1; f <= 2; f++) begin
      tick();
      n = 0;
      while (!fs_a && n < 200) begin tick(); n++; end
      check("timeout_resume_fs", 64'(n >= 200), 64'd0);
      check("frame_period", 64'(cyc - t0), 64'(f * int'(FT)));
      check("frame_cnt_step", 64'(fc_a), 64'(f0 + f));
    end

    // Reset mid-frame aborts immediately
    wait_pos(9, 5, "midrst");
    rst = 1'b1;
    tick();
    check("midrst_out_a", 64'({hs_a, vs_a, de_a, rgb_a}), 64'({2'b11, 25'h0}));
    check("midrst_out_b", 64'({hs_b, vs_b, de_b, rgb_b}), 64'h0);
    check("midrst_ctrl_a", 64'({req_a, x_a, y_a, ls_a, fs_a, busy_a, fc_a}), 64'h0);
    rst = 1'b0;
    tick();
    check("restart_fs", 64'({fs_a, x_a, y_a, busy_a}), 64'({1'b1, 4'd0, 3'd0, 1'b1}));
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
